// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: default frame size, sample width,
// reorder-buffer bank-state encoding and the index bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_LOG2N = 6;
  localparam int unsigned SAMPLE_W  = 32;
  localparam int unsigned MAX_LOG2N = 12;

  localparam logic [1:0] EMPTY    = 2'd0;
  localparam logic [1:0] FILLING  = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  localparam logic [1:0] DRAINING = 2'd3;

  // Reverse the low w bits of x; bits at and above w come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bit_reverse(input logic [MAX_LOG2N-1:0] x,
                                                       input int unsigned w);
    logic [MAX_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < w) r[4'(i)] = x[4'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_bank_ram.sv
// Simple dual-port sample RAM holding both ping-pong banks (bank select is the
// address MSB); synchronous read that holds its output when re is low.
module bitrev_bank_ram
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_W = FFT_LOG2N + 1,
  parameter int unsigned DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bitrev_reorder_buffer.sv
// Streaming bit-reversal reorder buffer: frames of 2^LOG2N samples fill one bank
// while the other drains in bit-reversed (or natural) index order.
module bitrev_reorder_buffer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = FFT_LOG2N,
  parameter int unsigned DATA_W = SAMPLE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rev_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last
);

  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  logic [1:0][1:0]   bank_q, bank_d;
  logic [1:0]        mode_q, mode_d;
  logic              wb_q, wb_d, rb_q, rb_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic              in_ready_d;
  logic              wr_fire, rd_fire, out_free;
  logic [LOG2N-1:0]  rd_addr;
  logic              s1_valid_q, s1_last_q;
  logic [LOG2N-1:0]  s1_index_q;
  logic [DATA_W-1:0] ram_rdata;

  // Bank state, pointers and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q   <= '0;
      mode_q   <= '0;
      wb_q     <= 1'b0;
      rb_q     <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      in_ready <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      mode_q   <= mode_d;
      wb_q     <= wb_d;
      rb_q     <= rb_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      in_ready <= in_ready_d;
    end
  end

  // Next-state: a write and a read in one cycle always hit different banks.
  always_comb begin
    bank_d   = bank_q;
    mode_d   = mode_q;
    wb_d     = wb_q;
    rb_d     = rb_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;

    wr_fire  = in_valid && in_ready;
    out_free = !out_valid || out_ready;
    rd_fire  = ((bank_q[rb_q] == FULL) || (bank_q[rb_q] == DRAINING)) && out_free;
    rd_addr  = mode_q[rb_q] ? LOG2N'(bit_reverse(MAX_LOG2N'(rd_cnt_q), LOG2N)) : rd_cnt_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_cnt_q == '0) begin
        mode_d[wb_q] = rev_en;
        bank_d[wb_q] = FILLING;
      end
      if (wr_cnt_q == CNT_LAST) begin
        bank_d[wb_q] = FULL;
        wb_d         = !wb_q;
      end
    end

    if (rd_fire) begin
      rd_cnt_d     = rd_cnt_q + LOG2N'(1);
      bank_d[rb_q] = DRAINING;
      if (rd_cnt_q == CNT_LAST) begin
        bank_d[rb_q] = EMPTY;
        rb_d         = !rb_q;
      end
    end

    in_ready_d = (bank_d[wb_d] == EMPTY) || (bank_d[wb_d] == FILLING);
  end

  bitrev_bank_ram #(
    .ADDR_W (LOG2N + 1),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr ({wb_q, wr_cnt_q}),
    .wdata (in_data),
    .re    (rd_fire),
    .raddr ({rb_q, rd_addr}),
    .rdata (ram_rdata)
  );

  // Two-stage read pipe (RAM word, then output register); both stall together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_index_q <= '0;
      s1_last_q  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
    end else if (out_free) begin
      out_valid  <= s1_valid_q;
      out_last   <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_data  <= ram_rdata;
        out_index <= s1_index_q;
      end
      s1_valid_q <= rd_fire;
      if (rd_fire) begin
        s1_index_q <= rd_addr;
        s1_last_q  <= (rd_cnt_q == CNT_LAST);
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder_buffer.sv
// Scoreboarded bench for bitrev_reorder_buffer; LOG2N = 3, 6 and 4 instances share
// stimulus and are muxed onto one monitor by sel.
module tb_bitrev_reorder_buffer;

  typedef struct {
    logic [31:0] data;
    logic [11:0] index;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, rev_en, in_valid, out_ready;
  logic [31:0] in_data;
  int          sel;
  int          cur_log2n;

  logic        ir3, ov3, ol3, ir6, ov6, ol6, ir4, ov4, ol4;
  logic [31:0] od3, od6, od4;
  logic [2:0]  idx3;
  logic [5:0]  idx6;
  logic [3:0]  idx4;

  logic        mon_ready, mon_valid, mon_last;
  logic [31:0] mon_data;
  logic [11:0] mon_index;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          pos = 0;
  int          pos_of_one = -1;
  int          first_valid_cyc = -1;
  int          last_valid_cyc = 0;
  int          valid_cnt = 0;
  int          last_acc_edge = 0;
  int          acc_cnt = 0;
  int          ir_drops = 0;
  bit          watch_ir = 1'b0;
  bit          rnd_rdy = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_data;
  logic [11:0] held_index;
  logic        held_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bitrev_reorder_buffer #(.LOG2N(3), .DATA_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .rev_en(rev_en), .in_valid(in_valid && (sel == 0)),
    .in_ready(ir3), .in_data(in_data), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .out_index(idx3), .out_last(ol3));

  bitrev_reorder_buffer #(.LOG2N(6), .DATA_W(32)) u_dut6 (
    .clk(clk), .rst(rst), .rev_en(rev_en), .in_valid(in_valid && (sel == 1)),
    .in_ready(ir6), .in_data(in_data), .out_valid(ov6), .out_ready(out_ready),
    .out_data(od6), .out_index(idx6), .out_last(ol6));

  bitrev_reorder_buffer #(.LOG2N(4), .DATA_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .rev_en(rev_en), .in_valid(in_valid && (sel == 2)),
    .in_ready(ir4), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .out_index(idx4), .out_last(ol4));

  always_comb begin
    case (sel)
      1: begin
        mon_ready = ir6; mon_valid = ov6; mon_last = ol6; mon_data = od6; mon_index = 12'(idx6);
      end
      2: begin
        mon_ready = ir4; mon_valid = ov4; mon_last = ol4; mon_data = od4; mon_index = 12'(idx4);
      end
      default: begin
        mon_ready = ir3; mon_valid = ov3; mon_last = ol3; mon_data = od3; mon_index = 12'(idx3);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_rev(input int unsigned v, input int bits);
    logic [11:0] r;
    r = '0;
    for (int k = 0; k < bits; k++)
      if (((v >> k) & 1) != 0) r = r | (12'd1 << (bits - 1 - k));
    return r;
  endfunction

  // Output monitor: scoreboard pop on every transfer, stability check while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 32'(mon_valid), 32'd1);
        check("hold_data", mon_data, held_data);
        check("hold_index", 32'(mon_index), 32'(held_index));
        check("hold_last", 32'(mon_last), 32'(held_last));
      end
      held = 1'b0;
      if (watch_ir && !mon_ready) ir_drops++;
      if (mon_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_ready) begin
          valid_cnt++;
          last_valid_cyc = cyc;
          if (sb_q.size() == 0) begin
            check("unexpected_word", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("out_data", mon_data, e.data);
            check("out_index", 32'(mon_index), 32'(e.index));
            check("out_last", 32'(mon_last), 32'(e.last));
            if (mon_data == 32'd1) pos_of_one = pos;
            pos = mon_last ? 0 : pos + 1;
          end
        end else begin
          held       = 1'b1;
          held_data  = mon_data;
          held_index = mon_index;
          held_last  = mon_last;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(1));
    end
  end

  // Drive one frame; expected output order is pushed once the frame is complete.
  task automatic send_frame(input bit rev, input bit rnd_data, input bit gaps, input int base);
    int          n;
    int          waitc;
    int          idx;
    bit          acc;
    logic [31:0] d;
    logic [31:0] fr[$];
    n = 1 << cur_log2n;
    for (int i = 0; i < n; i++) begin
      d = rnd_data ? $urandom : 32'(base + i);
      if (gaps) begin
        while ($urandom_range(1) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = d;
      rev_en   = rev;
      acc      = 1'b0;
      waitc    = 0;
      while (!acc) begin
        @(negedge clk);
        if (mon_ready) begin
          acc = 1'b1;
          acc_cnt++;
          if (i == n - 1) last_acc_edge = cyc + 1;
        end else begin
          waitc++;
          if (waitc > 2000) begin
            check("in_ready_timeout", 32'(mon_ready), 32'd1);
            in_valid = 1'b0;
            return;
          end
        end
        @(posedge clk); #1;
      end
      fr.push_back(d);
    end
    in_valid = 1'b0;
    for (int p = 0; p < n; p++) begin
      idx = rev ? int'(ref_rev(p, cur_log2n)) : p;
      sb_q.push_back('{data: fr[idx], index: 12'(idx), last: (p == n - 1)});
    end
  endtask

  task automatic wait_drain(input int limit);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < limit) begin
      @(posedge clk);
      c++;
    end
    check("drain_left", 32'(sb_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rev_en = 1'b0; out_ready = 1'b1;
    sel = 0; cur_log2n = 3;

    #12;
    check("rst_in_ready", 32'(mon_ready), 32'd0);
    check("rst_out_valid", 32'(mon_valid), 32'd0);
    check("rst_out_data", mon_data, 32'd0);
    check("rst_out_index", 32'(mon_index), 32'd0);
    check("rst_out_last", 32'(mon_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(mon_ready), 32'd1);

    // 8-point reversed frame and first-word latency.
    first_valid_cyc = -1;
    send_frame(1'b1, 1'b0, 1'b0, 0);
    wait_drain(100);
    check("t1_latency", 32'(first_valid_cyc - last_acc_edge), 32'd2);

    // Natural frame then reversed frame back to back: no bubbles, in_ready steady.
    first_valid_cyc = -1; valid_cnt = 0; ir_drops = 0; watch_ir = 1'b1;
    send_frame(1'b0, 1'b0, 1'b0, 0);
    send_frame(1'b1, 1'b0, 1'b0, 0);
    wait_drain(100);
    watch_ir = 1'b0;
    check("t3_word_count", 32'(valid_cnt), 32'd16);
    check("t3_no_bubble", 32'(last_valid_cyc - first_valid_cyc + 1), 32'(valid_cnt));
    check("t3_in_ready_drops", 32'(ir_drops), 32'd0);

    // 64-point frame: index 1 lands at output position 32.
    sel = 1; cur_log2n = 6; pos = 0; pos_of_one = -1;
    send_frame(1'b1, 1'b0, 1'b0, 0);
    wait_drain(300);
    check("t2_pos_of_1", 32'(pos_of_one), 32'd32);

    // Output stalled for 20 cycles with three frames offered.
    sel = 0; cur_log2n = 3; acc_cnt = 0; out_ready = 1'b0;
    fork
      begin
        send_frame(1'b1, 1'b0, 1'b0, 0);
        send_frame(1'b0, 1'b0, 1'b0, 16);
        send_frame(1'b1, 1'b0, 1'b0, 32);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        check("t4_accepted", 32'(acc_cnt), 32'd16);
        check("t4_in_ready_low", 32'(mon_ready), 32'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain(200);

    // Async reset in the middle of draining frame 2.
    valid_cnt = 0;
    send_frame(1'b1, 1'b0, 1'b0, 0);
    send_frame(1'b1, 1'b0, 1'b0, 100);
    c = 0;
    while (valid_cnt < 11 && c < 200) begin
      @(posedge clk);
      c++;
    end
    #3;
    rst = 1'b1;
    #1;
    check("t6_out_valid_async", 32'(mon_valid), 32'd0);
    check("t6_in_ready_rst", 32'(mon_ready), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0;
    @(posedge clk); #1;
    send_frame(1'b1, 1'b0, 1'b0, 0);
    wait_drain(100);

    // Random valid/ready over 100 frames of 16, random mode and data.
    sel = 2; cur_log2n = 4; pos = 0; rnd_rdy = 1'b1;
    for (int f = 0; f < 100; f++) send_frame(1'($urandom_range(1)), 1'b1, 1'b1, 0);
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain(2000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
